// File: rtl/md_book_dispatcher.sv
// md_book_dispatcher
//
// Routes decoded MDP3 book-update messages from the parser to one of
// NUM_BOOKS order-book instances, chosen by matching the message security ID
// against a run-time programmable slot table. A small FIFO absorbs parser
// traffic while an order book applies backpressure. Messages whose security
// ID matches no enabled slot are discarded and counted.
//
// Ports:
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   msg_valid/msg_ready  parser handshake; payload on sec_id, action,
//                        entry_type, price, quantity, num_orders
//   cfg_we/cfg_idx/      slot table write port: slot cfg_idx gets
//   cfg_sec_id/cfg_en    {cfg_en, cfg_sec_id}
//   book_valid           one-hot offer to order book i
//   book_ready           per-book accept
//   book_action ..       shared payload bus, held stable while offered
//   book_num_orders
//   drop_count           saturating count of unmatched messages
//   busy                 messages buffered or dispatch in progress
module md_book_dispatcher #(
    parameter int NUM_BOOKS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [31:0]          sec_id,
    input  logic [1:0]           action,
    input  logic [1:0]           entry_type,
    input  logic [63:0]          price,
    input  logic [15:0]          quantity,
    input  logic [7:0]           num_orders,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [31:0]          cfg_sec_id,
    input  logic                 cfg_en,
    output logic [NUM_BOOKS-1:0] book_valid,
    input  logic [NUM_BOOKS-1:0] book_ready,
    output logic [1:0]           book_action,
    output logic [1:0]           book_entry_type,
    output logic [63:0]          book_price,
    output logic [15:0]          book_quantity,
    output logic [7:0]           book_num_orders,
    output logic [15:0]          drop_count,
    output logic                 busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 124;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        ISSUE
    } state_t;

    logic [ENTRY_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [ENTRY_W-1:0]   head;
    logic [31:0]          head_sec;
    logic                 push;
    logic                 pop;

    logic [NUM_BOOKS-1:0] tbl_en_q;
    logic [31:0]          tbl_sec_q [NUM_BOOKS];
    logic [NUM_BOOKS-1:0] hit_onehot;
    logic                 hit;

    state_t               state_q;
    state_t               state_d;
    logic                 latch;
    logic                 drop;
    logic [NUM_BOOKS-1:0] target_q;
    logic [15:0]          drop_cnt_q;

    assign msg_ready  = (count_q != FULL_CNT);
    assign push       = msg_valid & msg_ready;
    assign head       = mem[rd_ptr_q];
    assign head_sec   = head[123:92];
    assign book_valid = (state_q == ISSUE) ? target_q : '0;
    assign drop_count = drop_cnt_q;
    assign busy       = (count_q != '0) | (state_q != IDLE);

    // Storage array has no reset; an empty count makes stale words unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {sec_id, action, entry_type, price, quantity, num_orders};
        end
    end

    // Pointers are exactly PTR_W wide, so natural overflow gives the wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Slot table; a write lands at the edge and is seen by the next lookup.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_en_q <= '0;
            for (int i = 0; i < NUM_BOOKS; i++) begin
                tbl_sec_q[i] <= '0;
            end
        end else if (cfg_we) begin
            tbl_en_q[cfg_idx]  <= cfg_en;
            tbl_sec_q[cfg_idx] <= cfg_sec_id;
        end
    end

    // Priority match: scanning upward and stopping at the first hit makes
    // the lowest-numbered matching slot win when several share an ID.
    always_comb begin
        hit_onehot = '0;
        hit        = 1'b0;
        for (int i = 0; i < NUM_BOOKS; i++) begin
            if (!hit && tbl_en_q[i] && (tbl_sec_q[i] == head_sec)) begin
                hit_onehot[i] = 1'b1;
                hit           = 1'b1;
            end
        end
    end

    // Dispatch FSM next-state. The head is popped only once it has either
    // been dropped or accepted by its target book, so ordering is preserved.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        latch   = 1'b0;
        drop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    latch   = 1'b1;
                    state_d = ISSUE;
                end else begin
                    pop     = 1'b1;
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if ((book_valid & book_ready) != '0) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The target is latched at lookup so later table writes cannot redirect
    // or withdraw a message already being offered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            target_q        <= '0;
            book_action     <= '0;
            book_entry_type <= '0;
            book_price      <= '0;
            book_quantity   <= '0;
            book_num_orders <= '0;
            drop_cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                target_q        <= hit_onehot;
                book_action     <= head[91:90];
                book_entry_type <= head[89:88];
                book_price      <= head[87:24];
                book_quantity   <= head[23:8];
                book_num_orders <= head[7:0];
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_md_book_dispatcher.sv
// tb_md_book_dispatcher
//
// Directed bench for md_book_dispatcher. Each scenario task drives its own
// stimulus and checks results against hand-computed values.
module tb_md_book_dispatcher;

    logic        clk;
    logic        reset_n;
    logic        msg_valid;
    logic        msg_ready;
    logic [31:0] sec_id;
    logic [1:0]  action;
    logic [1:0]  entry_type;
    logic [63:0] price;
    logic [15:0] quantity;
    logic [7:0]  num_orders;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [31:0] cfg_sec_id;
    logic        cfg_en;
    logic [3:0]  book_valid;
    logic [3:0]  book_ready;
    logic [1:0]  book_action;
    logic [1:0]  book_entry_type;
    logic [63:0] book_price;
    logic [15:0] book_quantity;
    logic [7:0]  book_num_orders;
    logic [15:0] drop_count;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_drops    = 0;

    md_book_dispatcher #(
        .NUM_BOOKS (4),
        .FIFO_DEPTH(4),
        .IDX_W     (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .msg_valid      (msg_valid),
        .msg_ready      (msg_ready),
        .sec_id         (sec_id),
        .action         (action),
        .entry_type     (entry_type),
        .price          (price),
        .quantity       (quantity),
        .num_orders     (num_orders),
        .cfg_we         (cfg_we),
        .cfg_idx        (cfg_idx),
        .cfg_sec_id     (cfg_sec_id),
        .cfg_en         (cfg_en),
        .book_valid     (book_valid),
        .book_ready     (book_ready),
        .book_action    (book_action),
        .book_entry_type(book_entry_type),
        .book_price     (book_price),
        .book_quantity  (book_quantity),
        .book_num_orders(book_num_orders),
        .drop_count     (drop_count),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [31:0] sid, input logic en);
        cfg_we     = 1'b1;
        cfg_idx    = idx;
        cfg_sec_id = sid;
        cfg_en     = en;
        tick();
        cfg_we     = 1'b0;
    endtask

    task automatic drive_msg(input logic [31:0] sid, input logic [1:0] act, input logic [1:0] et,
                             input logic [63:0] pr, input logic [15:0] qty, input logic [7:0] no);
        sec_id     = sid;
        action     = act;
        entry_type = et;
        price      = pr;
        quantity   = qty;
        num_orders = no;
    endtask

    // Offers one message for exactly one edge; only used while the FIFO has room.
    task automatic send_one(input logic [31:0] sid, input logic [1:0] act, input logic [1:0] et,
                            input logic [63:0] pr, input logic [15:0] qty, input logic [7:0] no);
        drive_msg(sid, act, et, pr, qty, no);
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if (msg_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_msg_ready: got %b expected 1", msg_ready);
        end
        tests_run++;
        if (book_valid !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid_busy: got valid=%b busy=%b expected 0000/0", book_valid, busy);
        end
        tests_run++;
        if (drop_count !== 16'd0 || book_price !== 64'd0 || book_quantity !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs: got drop=%h price=%h qty=%h expected zeros",
                     drop_count, book_price, book_quantity);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_route();
        book_ready = 4'b1111;
        cfg_write(2'd0, 32'd123, 1'b1);
        cfg_write(2'd1, 32'd122, 1'b1);
        send_one(32'd123, 2'd0, 2'd0, 64'hAE, 16'd1, 8'd0);
        tests_run++;
        if (book_valid !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL basic_valid_t0: got %b expected 0000", book_valid);
        end
        tick();
        tests_run++;
        if (book_valid !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL basic_valid_t1: got %b expected 0000", book_valid);
        end
        tick();
        tests_run++;
        if (book_valid !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL basic_valid_t2: got %b expected 0001", book_valid);
        end
        tests_run++;
        if ({book_action, book_entry_type, book_price, book_quantity, book_num_orders} !==
            {2'd0, 2'd0, 64'hAE, 16'd1, 8'd0}) begin
            tests_failed++;
            $display("[TB] FAIL basic_payload: got act=%h et=%h price=%h qty=%h no=%h expected 0/0/ae/1/0",
                     book_action, book_entry_type, book_price, book_quantity, book_num_orders);
        end
        tick();
        tests_run++;
        if (book_valid !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL basic_after_hs: got valid=%b busy=%b expected 0000/0", book_valid, busy);
        end
    endtask

    task automatic test_drop();
        logic seen;
        seen = 1'b0;
        tests_run++;
        if (drop_count !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL drop_initial: got %0d expected 0", drop_count);
        end
        send_one(32'd999, 2'd1, 2'd1, 64'h55, 16'd2, 8'd1);
        for (int c = 0; c < 4; c++) begin
            if (book_valid !== 4'b0000) seen = 1'b1;
            tick();
        end
        exp_drops++;
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL drop_no_valid: got valid seen=%b expected 0", seen);
        end
        tests_run++;
        if (drop_count !== exp_drops[15:0]) begin
            tests_failed++;
            $display("[TB] FAIL drop_count_inc: got %0d expected %0d", drop_count, exp_drops);
        end
        send_one(32'd122, 2'd1, 2'd2, 64'h1234_5678_9ABC_DEF0, 16'd7, 8'd3);
        tick();
        tick();
        tests_run++;
        if (book_valid !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL drop_then_route: got %b expected 0010", book_valid);
        end
        tests_run++;
        if ({book_action, book_entry_type, book_price, book_quantity, book_num_orders} !==
            {2'd1, 2'd2, 64'h1234_5678_9ABC_DEF0, 16'd7, 8'd3}) begin
            tests_failed++;
            $display("[TB] FAIL route_payload: got act=%h et=%h price=%h qty=%h no=%h expected 1/2/123456789abcdef0/7/3",
                     book_action, book_entry_type, book_price, book_quantity, book_num_orders);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] got_q [6];
        int          n_acc;
        int          n_del;
        logic        bad_onehot;
        logic        hold_bad_valid;
        logic        hold_bad_payload;
        logic        acc_now;
        logic        hs_now;
        logic [15:0] q_now;
        logic [3:0]  bv_now;

        for (int i = 0; i < 6; i++) got_q[i] = 16'd0;
        book_ready = 4'b1110;
        n_acc = 0;
        drive_msg(32'd123, 2'd2, 2'd1, 64'hCAFE_0001, 16'd1, 8'd9);
        msg_valid = 1'b1;
        for (int c = 0; c < 10 && msg_ready; c++) begin
            tick();
            n_acc++;
            drive_msg(32'd123, 2'd2, 2'd1, 64'hCAFE_0000 + 64'(n_acc + 1), 16'(n_acc + 1), 8'd9);
        end
        tests_run++;
        if (n_acc !== 4 || msg_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_fill: got accepted=%0d ready=%b expected 4/0", n_acc, msg_ready);
        end

        hold_bad_valid   = 1'b0;
        hold_bad_payload = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (book_valid !== 4'b0001) hold_bad_valid = 1'b1;
            if (book_quantity !== 16'd1 || book_price !== 64'hCAFE_0001) hold_bad_payload = 1'b1;
            tick();
        end
        tests_run++;
        if (hold_bad_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_hold_valid: got unstable=%b (last %b) expected steady 0001",
                     hold_bad_valid, book_valid);
        end
        tests_run++;
        if (hold_bad_payload !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_hold_payload: got qty=%0d price=%h expected 1/cafe0001",
                     book_quantity, book_price);
        end

        book_ready = 4'b1111;
        n_del      = 0;
        bad_onehot = 1'b0;
        for (int c = 0; c < 100 && n_del < 6; c++) begin
            acc_now = msg_valid && msg_ready;
            hs_now  = (book_valid & book_ready) != 4'b0000;
            q_now   = book_quantity;
            bv_now  = book_valid;
            tick();
            if (hs_now) begin
                got_q[n_del] = q_now;
                if (bv_now !== 4'b0001) bad_onehot = 1'b1;
                n_del++;
            end
            if (acc_now) begin
                n_acc++;
                if (n_acc < 6) begin
                    drive_msg(32'd123, 2'd2, 2'd1, 64'hCAFE_0000 + 64'(n_acc + 1), 16'(n_acc + 1), 8'd9);
                end else begin
                    msg_valid = 1'b0;
                end
            end
        end
        msg_valid = 1'b0;
        tests_run++;
        if (n_del !== 6 || n_acc !== 6) begin
            tests_failed++;
            $display("[TB] FAIL b2b_drain_count: got delivered=%0d accepted=%0d expected 6/6", n_del, n_acc);
        end
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (got_q[i] !== 16'(i + 1)) begin
                tests_failed++;
                $display("[TB] FAIL b2b_order_%0d: got qty %0d expected %0d", i, got_q[i], i + 1);
            end
        end
        tests_run++;
        if (bad_onehot !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_target: got non-0001 valid during drain expected 0001");
        end
        tests_run++;
        if (msg_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_idle_after: got ready=%b busy=%b expected 1/0", msg_ready, busy);
        end
    endtask

    task automatic test_priority();
        logic seen;
        cfg_write(2'd0, 32'd123, 1'b0);
        cfg_write(2'd2, 32'd123, 1'b1);
        book_ready = 4'b1011;
        send_one(32'd123, 2'd0, 2'd0, 64'h21, 16'd21, 8'd0);
        tick();
        tick();
        tests_run++;
        if (book_valid !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL prio_slot2: got %b expected 0100", book_valid);
        end
        cfg_write(2'd2, 32'd456, 1'b1);
        tests_run++;
        if (book_valid !== 4'b0100 || book_quantity !== 16'd21) begin
            tests_failed++;
            $display("[TB] FAIL prio_latched: got valid=%b qty=%0d expected 0100/21", book_valid, book_quantity);
        end
        book_ready = 4'b1111;
        tick();
        tests_run++;
        if (book_valid !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL prio_release: got %b expected 0000", book_valid);
        end
        cfg_write(2'd2, 32'd123, 1'b1);
        cfg_write(2'd0, 32'd123, 1'b1);
        send_one(32'd123, 2'd0, 2'd0, 64'h22, 16'd22, 8'd0);
        tick();
        tick();
        tests_run++;
        if (book_valid !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL prio_lowest: got %b expected 0001", book_valid);
        end
        tick();
        cfg_write(2'd0, 32'd123, 1'b0);
        cfg_write(2'd2, 32'd123, 1'b0);
        seen = 1'b0;
        send_one(32'd123, 2'd0, 2'd0, 64'h23, 16'd23, 8'd0);
        for (int c = 0; c < 4; c++) begin
            if (book_valid !== 4'b0000) seen = 1'b1;
            tick();
        end
        exp_drops++;
        tests_run++;
        if (seen !== 1'b0 || drop_count !== exp_drops[15:0]) begin
            tests_failed++;
            $display("[TB] FAIL prio_disabled_drop: got seen=%b drop=%0d expected 0/%0d",
                     seen, drop_count, exp_drops);
        end
    endtask

    task automatic test_saturation();
        // Preload the drop counter close to its ceiling.
        dut.drop_cnt_q <= 16'hFFFD;
        tick();
        for (int k = 0; k < 3; k++) begin
            send_one(32'd999, 2'd0, 2'd0, 64'h0, 16'd0, 8'd0);
            tick();
            tick();
            tests_run++;
            if (drop_count !== ((k == 0) ? 16'hFFFE : 16'hFFFF)) begin
                tests_failed++;
                $display("[TB] FAIL sat_step_%0d: got %h expected %h", k, drop_count,
                         (k == 0) ? 16'hFFFE : 16'hFFFF);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        cfg_write(2'd0, 32'd123, 1'b1);
        book_ready = 4'b0000;
        msg_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive_msg(32'd123, 2'd1, 2'd1, 64'hBEEF, 16'(40 + k), 8'd4);
            tick();
        end
        msg_valid = 1'b0;
        tick();
        tests_run++;
        if (book_valid !== 4'b0001 || msg_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_setup: got valid=%b ready=%b expected 0001/0", book_valid, msg_ready);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (book_valid !== 4'b0000 || busy !== 1'b0 || msg_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_outputs: got valid=%b busy=%b ready=%b expected 0000/0/1",
                     book_valid, busy, msg_ready);
        end
        tests_run++;
        if (drop_count !== 16'd0 || book_price !== 64'd0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_regs: got drop=%h price=%h expected 0/0", drop_count, book_price);
        end
        tick();
        reset_n    = 1'b1;
        book_ready = 4'b1111;
        seen       = 1'b0;
        send_one(32'd123, 2'd0, 2'd0, 64'h77, 16'd77, 8'd0);
        for (int c = 0; c < 5; c++) begin
            if (book_valid !== 4'b0000) seen = 1'b1;
            tick();
        end
        tests_run++;
        if (seen !== 1'b0 || drop_count !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_table_cleared: got seen=%b drop=%0d expected 0/1", seen, drop_count);
        end
        cfg_write(2'd0, 32'd123, 1'b1);
        send_one(32'd123, 2'd3, 2'd2, 64'h78, 16'd78, 8'd5);
        tick();
        tick();
        tests_run++;
        if (book_valid !== 4'b0001 || book_quantity !== 16'd78) begin
            tests_failed++;
            $display("[TB] FAIL midrst_reconfig: got valid=%b qty=%0d expected 0001/78", book_valid, book_quantity);
        end
        tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        msg_valid  = 1'b0;
        cfg_we     = 1'b0;
        cfg_idx    = 2'd0;
        cfg_sec_id = 32'd0;
        cfg_en     = 1'b0;
        book_ready = 4'b0000;
        drive_msg(32'd0, 2'd0, 2'd0, 64'd0, 16'd0, 8'd0);

        test_reset();
        test_basic_route();
        test_drop();
        test_back_to_back();
        test_priority();
        test_saturation();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
